// File: rtl/mult.sv
// Sequential signed 32x32 radix-2 Booth multiplier producing a 64-bit HI/LO product.
// One Booth iteration per clock, 32 iterations; start accepted only while idle.
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Multiplicando,
    input  logic [31:0] Multiplicador,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [32:0] m_q, m_d;
    logic [32:0] a_q, a_d;
    logic [31:0] q_q, q_d;
    logic        qm1_q, qm1_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [65:0] step_s;

    // One Booth step: conditional add/subtract of M, then arithmetic shift of {A,Q,Q-1}.
    function automatic logic [65:0] booth_step(input logic [32:0] a,
                                               input logic [31:0] q,
                                               input logic        qm1,
                                               input logic [32:0] m);
        logic [32:0] sum;
        case ({q[0], qm1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        booth_step = {sum[32], sum, q};
    endfunction

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        step_s  = booth_step(a_q, q_q, qm1_q, m_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = {Multiplicando[31], Multiplicando};
                    a_d     = 33'd0;
                    q_d     = Multiplicador;
                    qm1_d   = 1'b0;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // step_s is {A,Q,Q-1} after the shift.
                a_d   = step_s[65:33];
                q_d   = step_s[32:1];
                qm1_d = step_s[0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = step_s[64:33];
                    lo_d    = step_s[32:1];
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= 33'd0;
            a_q     <= 33'd0;
            q_q     <= 32'd0;
            qm1_q   <= 1'b0;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult.sv
// Directed self-checking bench for mult: products, latency, ignored start/operands,
// mid-operation reset and back-to-back operation with start held high.
module tb_mult;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] hi_s;
    logic [31:0] lo_s;
    logic        busy_s;
    logic        done_s;

    int n_tests = 0;
    int n_fail  = 0;

    mult dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .Multiplicando (mcand),
        .Multiplicador (mplier),
        .HI            (hi_s),
        .LO            (lo_s),
        .busy          (busy_s),
        .done          (done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one multiply and check latency, busy length and the product.
    task automatic run_mult(input string tag, input logic [31:0] m, input logic [31:0] q,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        int busy_cnt;
        mcand  = m;
        mplier = q;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        mcand    = $urandom;
        mplier   = $urandom;
        lat      = -1;
        busy_cnt = busy_s ? 1 : 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (busy_s) busy_cnt++;
            if (done_s && lat < 0) begin
                lat = c;
                check({tag, " product"}, {hi_s, lo_s}, {ehi, elo});
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " hold"}, {hi_s, lo_s}, {ehi, elo});
    endtask

    initial begin
        int dones;
        int d1;
        int d2;
        logic changed;
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = 32'd0;
        mplier = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset HI/LO", {hi_s, lo_s}, 64'd0);
        check("reset busy/done", {62'd0, busy_s, done_s}, 64'd0);

        run_mult("3x5",     32'd3,          32'd5,          32'h00000000, 32'h0000000F);
        run_mult("-2x3",    32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA);
        run_mult("-1x-1",   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000, 32'h00000001);
        run_mult("min*min", 32'h80000000,   32'h80000000,   32'h40000000, 32'h00000000);
        run_mult("max*max", 32'h7FFFFFFF,   32'h7FFFFFFF,   32'h3FFFFFFF, 32'h00000001);
        run_mult("min*max", 32'h80000000,   32'h7FFFFFFF,   32'hC0000000, 32'h80000000);
        run_mult("x*-1",    32'h12345678,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'hEDCBA988);

        // 7x9 with operand changes and start pulses during RUN; prior product is 0xC0000000_80000000 style.
        run_mult("prior",   32'h80000000,   32'h7FFFFFFF,   32'hC0000000, 32'h80000000);
        mcand  = 32'd7;
        mplier = 32'd9;
        start  = 1'b1;
        tick();
        start   = 1'b0;
        dones   = 0;
        changed = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (done_s) begin
                dones++;
                check("7x9 product", {hi_s, lo_s}, 64'd63);
            end else if (dones == 0 && {hi_s, lo_s} != {32'hC0000000, 32'h80000000}) begin
                changed = 1'b1;
            end
            if (c == 5 || c == 20) begin
                mcand  = 32'd1234;
                mplier = 32'hFFFF0000;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("7x9 done count", 64'(dones), 64'd1);
        check("7x9 prior held", {63'd0, changed}, 64'd0);
        check("7x9 idle after", {63'd0, busy_s}, 64'd0);

        // Reset at iteration 10 aborts the operation.
        mcand  = 32'd1000;
        mplier = 32'd1000;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort HI/LO", {hi_s, lo_s}, 64'd0);
        check("abort busy/done", {62'd0, busy_s, done_s}, 64'd0);
        dones = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done_s) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        run_mult("1000x1000", 32'd1000, 32'd1000, 32'h00000000, 32'h000F4240);

        // Back-to-back with start held high.
        mcand  = 32'd6;
        mplier = 32'd7;
        start  = 1'b1;
        tick();
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (done_s && d1 < 0) begin
                d1 = c;
                check("b2b first LO", {hi_s, lo_s}, 64'd42);
            end else if (done_s && d2 < 0) begin
                d2 = c;
                check("b2b second LO", {hi_s, lo_s}, 64'd56);
            end
            if (d1 > 0 && c == d1 + 1) begin
                check("b2b idle gap", {63'd0, busy_s}, 64'd0);
                mcand  = 32'd7;
                mplier = 32'd8;
            end
            if (d2 > 0) start = 1'b0;
        end
        check("b2b first at", 64'(d1), 64'd32);
        check("b2b spacing", 64'(d2 - d1), 64'd34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
